// File: rtl/ldm_stm_seq_if.sv
// Request, register-file and memory bundle for the LDM/STM block-transfer sequencer.
// The slave modport is the sequencer; the master modport is the surrounding core or test environment.
interface ldm_stm_seq_if;
  logic        start;
  logic        load;
  logic [15:0] reglist;
  logic [31:0] base_addr;
  logic [3:0]  rn;
  logic [31:0] rd1;
  logic [3:0]  ra1;
  logic        we3;
  logic [3:0]  wa3;
  logic [31:0] wd3;
  logic        pc_load;
  logic [31:0] pc_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        done;

  modport slave (
    input  start, load, reglist, base_addr, rn, rd1, mem_ack, mem_rdata,
    output ra1, we3, wa3, wd3, pc_load, pc_wdata,
           mem_req, mem_we, mem_addr, mem_wdata, busy, done
  );

  modport master (
    output start, load, reglist, base_addr, rn, rd1, mem_ack, mem_rdata,
    input  ra1, we3, wa3, wd3, pc_load, pc_wdata,
           mem_req, mem_we, mem_addr, mem_wdata, busy, done
  );
endinterface

// File: rtl/ldm_stm_seq.sv
// LDM/STM block-transfer sequencer: walks a 16-bit register mask lowest bit first, increment-after.
// Define LDM_STM_WB_EN to add a WB state that writes base+4*count back to register rn.
module ldm_stm_seq (
  input  logic         clk,
  input  logic         reset,
  ldm_stm_seq_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
`ifdef LDM_STM_WB_EN
    WB   = 2'd2,
`endif
    DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_load;
  logic [15:0] r_mask;
  logic [31:0] r_base;
  logic [4:0]  r_count;
`ifdef LDM_STM_WB_EN
  logic [3:0]  r_rn;
`else
  logic        w_unused_rn;
  assign w_unused_rn = ^bus.rn;
`endif

  logic [15:0] w_lsb;
  logic [15:0] w_mask_rem;
  logic [3:0]  w_cur;
  logic [31:0] w_addr;

  // Two's-complement trick isolates the lowest set bit of the remaining mask.
  assign w_lsb      = r_mask & (~r_mask + 16'd1);
  assign w_mask_rem = r_mask & ~w_lsb;
  assign w_addr     = r_base + {25'd0, r_count, 2'b00};

  always_comb begin
    w_cur = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (w_lsb[i]) w_cur = 4'(i);
    end
  end

  always_comb begin
    w_state_next  = r_state;
    bus.ra1       = 4'd0;
    bus.we3       = 1'b0;
    bus.wa3       = 4'd0;
    bus.wd3       = 32'd0;
    bus.pc_load   = 1'b0;
    bus.pc_wdata  = 32'd0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = 32'd0;
    bus.mem_wdata = 32'd0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) w_state_next = (bus.reglist == 16'd0) ? DONE : XFER;
      end
      XFER: begin
        bus.busy     = 1'b1;
        bus.mem_req  = 1'b1;
        bus.mem_we   = ~r_load;
        bus.mem_addr = w_addr;
        if (!r_load) begin
          bus.ra1       = w_cur;
          bus.mem_wdata = bus.rd1;
        end
        if (bus.mem_ack) begin
          if (r_load && (w_cur == 4'd15)) begin
            bus.pc_load  = 1'b1;
            bus.pc_wdata = bus.mem_rdata;
          end else if (r_load) begin
            bus.we3 = 1'b1;
            bus.wa3 = w_cur;
            bus.wd3 = bus.mem_rdata;
          end
          if (w_mask_rem == 16'd0) begin
`ifdef LDM_STM_WB_EN
            w_state_next = WB;
`else
            w_state_next = DONE;
`endif
          end
        end
      end
`ifdef LDM_STM_WB_EN
      // count already covers every transfer, so w_addr is the final base.
      WB: begin
        bus.busy = 1'b1;
        if (r_rn == 4'd15) begin
          bus.pc_load  = 1'b1;
          bus.pc_wdata = w_addr;
        end else begin
          bus.we3 = 1'b1;
          bus.wa3 = r_rn;
          bus.wd3 = w_addr;
        end
        w_state_next = DONE;
      end
`endif
      DONE: begin
        bus.done     = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_load  <= 1'b0;
      r_mask  <= 16'd0;
      r_base  <= 32'd0;
      r_count <= 5'd0;
`ifdef LDM_STM_WB_EN
      r_rn    <= 4'd0;
`endif
    end else begin
      r_state <= w_state_next;
      if ((r_state == IDLE) && bus.start) begin
        r_load  <= bus.load;
        r_mask  <= bus.reglist;
        r_base  <= bus.base_addr;
        r_count <= 5'd0;
`ifdef LDM_STM_WB_EN
        r_rn    <= bus.rn;
`endif
      end else if ((r_state == XFER) && bus.mem_ack) begin
        r_mask  <= w_mask_rem;
        r_count <= r_count + 5'd1;
      end
    end
  end
endmodule

// File: tb/tb_ldm_stm_seq.sv
// Scoreboard bench for ldm_stm_seq: expected bus/regfile events queued at start, popped on each DUT event.
// Register-file read model rd1 = 0x1000_0000 + ra1; memory read model rdata = addr ^ 0xA5A5_0000.
module tb_ldm_stm_seq;
  logic clk = 1'b0;
  logic reset;

  ldm_stm_seq_if bus ();

  ldm_stm_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mem;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we3;
    logic [3:0]  wa3;
    logic [31:0] wd3;
    logic        pcl;
    logic [31:0] pcw;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   ack_delay = 0;
  int   wcnt = 0;
  int   n_evt = 0;
  logic ack_gen = 1'b0;
  logic force_ack = 1'b0;

  always_comb bus.rd1       = 32'h1000_0000 + {28'd0, bus.ra1};
  always_comb bus.mem_ack   = ack_gen | force_ack;
  always_comb bus.mem_rdata = bus.mem_ack ? (bus.mem_addr ^ 32'hA5A5_0000) : 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk_mem(input logic ld, input int r, input logic [31:0] a);
    exp_t e;
    e = '{mem: 1'b1, we: ~ld, addr: a, wdata: 32'd0, we3: 1'b0, wa3: 4'd0,
          wd3: 32'd0, pcl: 1'b0, pcw: 32'd0};
    if (!ld) begin
      e.wdata = 32'h1000_0000 + 32'(r);
    end else if (r == 15) begin
      e.pcl = 1'b1;
      e.pcw = a ^ 32'hA5A5_0000;
    end else begin
      e.we3 = 1'b1;
      e.wa3 = 4'(r);
      e.wd3 = a ^ 32'hA5A5_0000;
    end
    return e;
  endfunction

  // Memory responder and scoreboard monitor.
  always @(negedge clk) begin
    if (!bus.mem_req) begin
      ack_gen = 1'b0;
      wcnt = 0;
    end else if (wcnt >= ack_delay) begin
      ack_gen = 1'b1;
      wcnt = 0;
    end else begin
      ack_gen = 1'b0;
      wcnt++;
    end
    #1;
    if ((bus.mem_req && bus.mem_ack) || bus.we3 || bus.pc_load) begin
      check("sb_pending", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        n_evt++;
        $display("event %0d: req=%b addr=%h we=%b wdata=%h we3=%b wa3=%0d wd3=%h pc_load=%b pc=%h",
                 n_evt, bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_wdata,
                 bus.we3, bus.wa3, bus.wd3, bus.pc_load, bus.pc_wdata);
        check("mem_req", 32'(bus.mem_req), 32'(e.mem));
        if (e.mem) begin
          check("mem_addr", bus.mem_addr, e.addr);
          check("mem_we", 32'(bus.mem_we), 32'(e.we));
          if (e.we) check("mem_wdata", bus.mem_wdata, e.wdata);
        end
        check("we3", 32'(bus.we3), 32'(e.we3));
        check("pc_load", 32'(bus.pc_load), 32'(e.pcl));
        if (e.we3) begin
          check("wa3", 32'(bus.wa3), 32'(e.wa3));
          check("wd3", bus.wd3, e.wd3);
        end
        if (e.pcl) check("pc_wdata", bus.pc_wdata, e.pcw);
      end
    end else if (bus.mem_req && (sb_q.size() != 0) && sb_q[0].mem) begin
      check("hold_addr", bus.mem_addr, sb_q[0].addr);
      check("hold_we", 32'(bus.mem_we), 32'(sb_q[0].we));
      if (sb_q[0].we) check("hold_wdata", bus.mem_wdata, sb_q[0].wdata);
    end
  end

  task automatic push_list(input logic ld, input logic [15:0] rl, input logic [31:0] base,
                           input logic [3:0] rnv, output int n);
    n = 0;
    for (int r = 0; r < 16; r++) begin
      if (rl[r]) begin
        sb_q.push_back(mk_mem(ld, r, base + 32'(4 * n)));
        n++;
      end
    end
`ifdef LDM_STM_WB_EN
    if (n > 0) begin
      exp_t e;
      e = '{mem: 1'b0, we: 1'b0, addr: 32'd0, wdata: 32'd0, we3: 1'b0, wa3: 4'd0,
            wd3: 32'd0, pcl: 1'b0, pcw: 32'd0};
      if (rnv == 4'd15) begin
        e.pcl = 1'b1;
        e.pcw = base + 32'(4 * n);
      end else begin
        e.we3 = 1'b1;
        e.wa3 = rnv;
        e.wd3 = base + 32'(4 * n);
      end
      sb_q.push_back(e);
    end
`else
    if (rnv == 4'd15) n = n + 0;
`endif
  endtask

  task automatic run_xfer(input logic ld, input logic [15:0] rl, input logic [31:0] base,
                          input logic [3:0] rnv, input int dly);
    int n;
    int exp_lat;
    int k;
    int busy_cycles;
    @(negedge clk);
    ack_delay = dly;
    push_list(ld, rl, base, rnv, n);
    exp_lat = (n == 0) ? 1 : n * (dly + 1) + 1;
`ifdef LDM_STM_WB_EN
    if (n > 0) exp_lat = exp_lat + 1;
`endif
    bus.start = 1'b1;
    bus.load = ld;
    bus.reglist = rl;
    bus.base_addr = base;
    bus.rn = rnv;
    @(negedge clk);
    bus.start = 1'b0;
    k = 1;
    busy_cycles = 0;
    while (k <= 200) begin
      #2;
      if (bus.done) break;
      if (bus.busy) busy_cycles++;
      @(negedge clk);
      k++;
    end
    check("done_latency", 32'(k), 32'(exp_lat));
    check("busy_cycles", 32'(busy_cycles), 32'(exp_lat - 1));
    check("busy_in_done", 32'(bus.busy), 32'd0);
    @(negedge clk);
    #2;
    check("done_pulse", 32'(bus.done), 32'd0);
    check("idle_req", 32'(bus.mem_req), 32'd0);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    int n_tmp;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.load = 1'b0;
    bus.reglist = 16'd0;
    bus.base_addr = 32'd0;
    bus.rn = 4'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #2;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_we3", 32'(bus.we3), 32'd0);
    check("rst_pc_load", 32'(bus.pc_load), 32'd0);

    run_xfer(1'b1, 16'h0006, 32'h0000_0100, 4'd0, 0);
    run_xfer(1'b0, 16'h8001, 32'h0000_0200, 4'd0, 3);
    run_xfer(1'b1, 16'h0000, 32'h0000_0280, 4'd0, 0);
    run_xfer(1'b1, 16'h8000, 32'h0000_0400, 4'd0, 0);
    run_xfer(1'b0, 16'h0007, 32'hFFFF_FFF8, 4'd0, 1);
    run_xfer(1'b1, 16'hFFFF, 32'h0000_1000, 4'd0, 0);
    run_xfer(1'b0, 16'hA5A5, 32'h0000_2000, 4'd0, 2);

    // start raised in the DONE cycle must be dropped.
    @(negedge clk);
    bus.start = 1'b1;
    bus.load = 1'b1;
    bus.reglist = 16'd0;
    @(negedge clk);
    #2;
    check("done_state", 32'(bus.done), 32'd1);
    bus.reglist = 16'h0001;
    @(negedge clk);
    bus.start = 1'b0;
    #2;
    check("start_in_done_req", 32'(bus.mem_req), 32'd0);
    check("start_in_done_busy", 32'(bus.busy), 32'd0);
    check("start_in_done_done", 32'(bus.done), 32'd0);

    // Reset in the middle of a 4-register LDM.
    @(negedge clk);
    ack_delay = 1000;
    push_list(1'b1, 16'h000F, 32'h0000_0300, 4'd0, n_tmp);
    bus.start = 1'b1;
    bus.load = 1'b1;
    bus.reglist = 16'h000F;
    bus.base_addr = 32'h0000_0300;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    check("mid_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    force_ack = 1'b1;
    #2;
    check("post_rst_busy", 32'(bus.busy), 32'd0);
    check("post_rst_req", 32'(bus.mem_req), 32'd0);
    check("post_rst_addr", bus.mem_addr, 32'd0);
    check("post_rst_we3", 32'(bus.we3), 32'd0);
    check("post_rst_pc", 32'(bus.pc_load), 32'd0);
    @(negedge clk);
    #2;
    check("late_ack_req", 32'(bus.mem_req), 32'd0);
    check("late_ack_we3", 32'(bus.we3), 32'd0);
    check("late_ack_done", 32'(bus.done), 32'd0);
    force_ack = 1'b0;
    sb_q.delete();
    run_xfer(1'b0, 16'h0030, 32'h0000_0500, 4'd0, 1);

    // Base writeback vectors; with writeback disabled no WB event is expected.
    run_xfer(1'b1, 16'h000F, 32'h0000_0300, 4'd4, 0);
    run_xfer(1'b1, 16'h0006, 32'h0000_0600, 4'd2, 0);
    run_xfer(1'b1, 16'h0003, 32'h0000_0700, 4'd15, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/ldm_stm_seq.md
LDM_STM_SEQ -- requirements
Module: ldm_stm_seq

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-003 SHALL have port: start  input  1  one-cycle request to begin a block transfer; honoured only in IDLE.
REQ-004 SHALL have port: load  input  1  sampled with start; 1=LDM (memory to registers), 0=STM (registers to memory).
REQ-005 SHALL have port: reglist  input  16  register mask sampled with start; bit n selects register n.
REQ-006 SHALL have port: base_addr  input  32  start address sampled with start; increment-after addressing.
REQ-007 SHALL have port: rn  input  4  base register index sampled with start; used only when LDM_STM_WB_EN is defined.
REQ-008 SHALL have port: rd1  input  32  register-file read data for ra1.
REQ-009 SHALL have port: ra1  output  4  register-file read address; the current register during STM.
REQ-010 SHALL have port: we3 / wa3 / wd3  output  1/4/32  register-file write enable, address and data.
REQ-011 SHALL have port: pc_load / pc_wdata  output  1/32  r15 load strobe and value (the register file holds no r15).
REQ-012 SHALL have port: mem_req / mem_we / mem_addr / mem_wdata  output  1/1/32/32  memory request bundle.
REQ-013 SHALL have port: mem_ack / mem_rdata  input  1/32  memory completion and load data.
REQ-014 SHALL have port: busy / done  output  1/1  busy=transfer in progress; done=one-cycle completion pulse.

Function
REQ-015 SHALL implement the states IDLE, XFER, WB and DONE.
REQ-016 SHALL, in IDLE with start=1, latch load, reglist, base_addr and rn, clear the transfer count, and go to XFER; if reglist==0 it SHALL go to DONE instead.
REQ-017 SHALL, in XFER, select the lowest set bit of the remaining mask as the current register (cur) and drive mem_req=1, mem_addr=base+4*count and mem_we=~load.
REQ-018 SHALL, for STM in XFER, drive ra1=cur and mem_wdata=rd1 combinationally.
REQ-019 SHALL hold mem_req, mem_addr, mem_we and mem_wdata stable until mem_ack; with no mem_ack, XFER SHALL wait indefinitely.
REQ-020 SHALL, on the mem_ack cycle of an LDM with cur!=15, assert we3=1, wa3=cur and wd3=mem_rdata in that same cycle.
REQ-021 SHALL, on the mem_ack cycle of an LDM with cur==15, assert pc_load=1 and pc_wdata=mem_rdata, and SHALL keep we3=0.
REQ-022 SHALL, on mem_ack, clear bit cur from the mask and increment count; if the mask is then empty it SHALL go to WB when LDM_STM_WB_EN is defined, else to DONE; otherwise it SHALL stay in XFER.
REQ-023 SHALL allow back-to-back transfers: with mem_ack held at 1, there is one transfer per cycle.
REQ-024 SHALL, in DONE, pulse done=1 for exactly one cycle and then return to IDLE; busy=1 in XFER and WB only.
REQ-025 SHALL ignore start outside IDLE, including in the DONE cycle.
REQ-026 SHALL keep count 5 bits wide (max 16) and address arithmetic modulo 2^32, so the address wraps past 0xFFFFFFFC.
REQ-027 SHALL drive we3, pc_load and mem_req to 0 in every cycle not named above.

Reset
REQ-028 SHALL, on reset=1 at posedge clk, go to IDLE and clear the mask, count and latched fields, from any state including mid-XFER.
REQ-029 SHALL hold all outputs at 0 after reset until the next start; a mem_ack that arrives after reset SHALL be ignored.

Configuration
REQ-030 SHALL, with LDM_STM_WB_EN defined, spend one WB cycle asserting we3=1, wa3=rn_latched and wd3=base+4*count, then go to DONE; with rn==15 it SHALL use pc_load/pc_wdata instead.
REQ-031 SHALL, with LDM_STM_WB_EN undefined, contain no WB state, ignore rn, and never write back the base register.
REQ-032 SHALL, when LDM_STM_WB_EN is defined and an LDM list contains rn, let the WB write win because it occurs last.

Verification
REQ-033 SHALL cover: LDM, reglist=0x0006, base=0x100, mem_ack every cycle -> r1<=rdata@0x100 and r2<=rdata@0x104 in consecutive cycles, then done one cycle later.
REQ-034 SHALL cover: STM, reglist=0x8001, base=0x200, mem_ack delayed 3 cycles each -> writes of r0 then r15 at 0x200 and 0x204, with the request bundle stable while waiting.
REQ-035 SHALL cover: start with reglist=0 -> no mem_req, done=1 on the next cycle, busy never asserted.
REQ-036 SHALL cover: LDM, reglist=0x8000 -> pc_load=1, pc_wdata=mem_rdata, we3=0.
REQ-037 SHALL cover: reset asserted in the middle of a 4-register transfer -> IDLE the next cycle, all outputs 0, a late mem_ack ignored, and a following start accepted.
REQ-038 SHALL cover: with LDM_STM_WB_EN, LDM, rn=4, reglist=0x000F, base=0x300 -> WB writes r4=0x310 after the r3 load.
